hex_key_encoder: RTL and testbench
==================================

// Module: hex_key_encoder
// PURPOSE
// - Front-end feeding the 16-bit hex shift-register stage.
// - Turns 16 raw board switches and a raw delete button into clean {hex, add} and del one-cycle pulses.
// - Pulses are spaced so the consumer's post-edit lockout never drops an event.
// - Per-input debounce, sw edge detection, pending-event queue (lowest index first), FSM pacing.
// PARAMETERS
// - DEBOUNCE_CYCLES  1_000_000   cycles an input must hold a new level before debounced value changes
// - PULSE_GAP        10_000_002  min cycles from one add/del pulse to next; >= consumer lockout + 2
// - CNT_W            24          width of debounce and gap counters; must hold max(DEBOUNCE_CYCLES, PULSE_GAP)
// PORTS
// - sys_clk   in   1   system clock, all logic on rising edge
// - sys_rstn  in   1   synchronous active-low reset, sampled on sys_clk rising edge
// - sw        in   16  raw switches, asynchronous to sys_clk
// - btn_del   in   1   raw delete button, active high, asynchronous
// - hex       out  4   index of switch that produced current add; held until next add
// - add       out  1   one-cycle pulse: append hex
// - del       out  1   one-cycle pulse: drop low nibble
// - busy      out  1   high in ARM/PULSE/HOLDOFF or when pending events exist
// BEHAVIOUR
// - Decided: one clock, sys_clk; reset sys_rstn is synchronous, active-low.
// - Reset: hex=0, add=0, del=0, busy=1; debounce/gap counters=0; pending=0; del_pend=0; state=ARM.
// - Reset mid-operation wins unconditionally; in-flight pulse/pending events discarded.
// - Input path: 2-flop synchroniser per input (17), then debouncer.
// - Debounced value changes only after synced input differs from it for DEBOUNCE_CYCLES consecutive cycles.
// - Debounce counter clears on any bounce back.
// - Debounced regs start at reset from synced inputs, not 0.
// - Edge detect: rise = deb & ~deb_q (per bit). pending |= rise each cycle. del_pend set on btn_del debounced rise.
// - Edges are ignored while state == ARM.
// - FSM states:
//   - ARM: DEBOUNCE_CYCLES cycles after reset, lets debouncers settle; switches on at reset give no add; -> IDLE.
//   - IDLE: if pending != 0 -> PULSE(add); else if del_pend -> PULSE(del); else stay.
//   - PULSE: exactly one cycle.
//     - add: hex <= lowest set index of pending; clear that bit; add=1.
//     - del: clear del_pend; del=1.
//     - -> HOLDOFF.
//   - HOLDOFF: gap counter runs; -> IDLE when PULSE_GAP-1 cycles elapsed.
//     - Next pulse edge is exactly PULSE_GAP cycles after previous if already queued.
// - Priority: pending adds before del; among adds, lowest sw index first.
// - Simultaneous edges:
//   - Multiple sw bits rising in same cycle queue independently.
//   - An edge of a bit already pending coalesces (one add).
//   - Edges arriving during PULSE/HOLDOFF are queued, never lost.
// - add and del never high in same cycle; hex changes only in the cycle add rises.
// - Arithmetic: counters saturate-free, compared with ==; width CNT_W; sizing is integrator's responsibility.
// CONFIGURATION
// - Macro HEX_KEY_BOTH_EDGES_EN.
// - Defined: sw event = deb ^ deb_q (switch on or off both enqueue an add).
// - Undefined: only off->on (rise) enqueues; off transitions silent.
// - btn_del always rise-only.
// STRUCTURE
// - Shared package/header hex_key_pkg: FSM state encodings (ARM, IDLE, PULSE, HOLDOFF), default DEBOUNCE_CYCLES/PULSE_GAP.
// - Lockout constant shared with shift-register stage so PULSE_GAP tracks it.
// - One sub-module: key_debounce (sync + counter, params DEBOUNCE_CYCLES, CNT_W), instantiated 17x via generate.
// - Top holds edge detect, pending queue, priority encoder, FSM.
// TESTING (DEBOUNCE_CYCLES=4, PULSE_GAP=8)
// - Reset with sw=16'h0010 held -> no add after ARM; busy falls after 4 cycles; hex=0.
// - sw[5] 0->1 with 3 bounces <4 cycles, then stable -> one add, hex=5; add high 1 cycle.
// - sw[2] and sw[9] rise same cycle -> add hex=2, then add hex=9 exactly 8 cycles later.
// - btn_del rise during HOLDOFF of an add -> del pulse 8 cycles after add; never overlaps add.
// - sw[3] rise and btn_del rise same cycle -> add hex=3 first, del 8 cycles later.
// - sw[7] 1->0: no add without HEX_KEY_BOTH_EDGES_EN; add hex=7 with it.
// - sys_rstn low during HOLDOFF with 2 pending -> all outputs reset; no queued pulses after release.

Source files
------------

// File: rtl/hex_key_pkg.sv
// Shared definitions for the hex key encoder slice.
// - state_t: pacing FSM encodings (ARM, IDLE, PULSE, HOLDOFF)
// - LOCKOUT_CYCLES: post-edit lockout of the downstream shift-register stage;
//   DEF_PULSE_GAP is derived from it so the pulse spacing always clears it.
// - lowest_index(): priority encoder, lowest set bit wins.
package hex_key_pkg;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        PULSE,
        HOLDOFF
    } state_t;

    localparam int unsigned NUM_SW              = 16;
    localparam int unsigned LOCKOUT_CYCLES      = 10_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_PULSE_GAP       = LOCKOUT_CYCLES + 2;
    localparam int unsigned DEF_CNT_W           = 24;

    function automatic logic [3:0] lowest_index(input logic [NUM_SW-1:0] v);
        logic [3:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            if (v[i] && !found) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_key_encoder_if.sv
// Bundle between the raw board inputs / consumer and hex_key_encoder.
// - sw[15:0], btn_del : raw asynchronous inputs
// - hex[3:0], add     : append-nibble event (hex held until next add)
// - del               : drop-nibble event
// - busy              : encoder still has work in flight
// modport slave is the encoder side, master the board/consumer side.
interface hex_key_encoder_if;
    import hex_key_pkg::*;

    logic [NUM_SW-1:0] sw;
    logic              btn_del;
    logic [3:0]        hex;
    logic              add;
    logic              del;
    logic              busy;

    modport master (output sw, btn_del, input hex, add, del, busy);
    modport slave  (input sw, btn_del, output hex, add, del, busy);

endinterface

// File: rtl/hex_key_encoder_key_debounce.sv
// key_debounce: 2-flop synchroniser followed by a consecutive-cycle debouncer.
// - clk, rstn : clock, synchronous active-low reset
// - raw       : asynchronous input
// - deb       : debounced level; follows the synced input only after it has
//               differed for DEBOUNCE_CYCLES consecutive cycles
module key_debounce
    import hex_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic deb
);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // Synchroniser keeps sampling through reset so deb can load the real level.
    always_ff @(posedge clk) begin
        sync_a <= raw;
        sync_b <= sync_a;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            deb <= sync_b;
            cnt <= '0;
        end else if (sync_b != deb) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync_b;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/hex_key_encoder.sv
// hex_key_encoder: turns 16 raw switches and a delete button into paced
// {hex, add} / del single-cycle pulses for the hex shift-register stage.
// - sys_clk, sys_rstn : clock, synchronous active-low reset
// - bus (slave)       : sw, btn_del in; hex, add, del, busy out
// Build option HEX_KEY_BOTH_EDGES_EN: when defined, a switch turning off also
// enqueues an add; otherwise only off->on does. btn_del is always rise-only.
module hex_key_encoder
    import hex_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_GAP       = DEF_PULSE_GAP,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input logic               sys_clk,
    input logic               sys_rstn,
    hex_key_encoder_if.slave  bus
);

    logic [NUM_SW:0]   raw;
    logic [NUM_SW:0]   deb;
    logic [NUM_SW:0]   deb_q;
    logic [NUM_SW-1:0] sw_evt;
    logic              del_rise;
    logic [NUM_SW-1:0] pending;
    logic              del_pend;
    logic [NUM_SW-1:0] clr;
    logic [3:0]        sel;
    logic [3:0]        hex_q;
    logic              is_add;
    logic              take_add;
    logic              take_del;
    logic              edges_en;
    logic [CNT_W-1:0]  cnt;
    state_t            state;
    state_t            state_next;

    assign raw = {bus.btn_del, bus.sw};

    for (genvar g = 0; g <= NUM_SW; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk  (sys_clk),
            .rstn (sys_rstn),
            .raw  (raw[g]),
            .deb  (deb[g])
        );
    end

    always_ff @(posedge sys_clk) begin
        deb_q <= deb;
    end

`ifdef HEX_KEY_BOTH_EDGES_EN
    assign sw_evt = deb[NUM_SW-1:0] ^ deb_q[NUM_SW-1:0];
`else
    assign sw_evt = deb[NUM_SW-1:0] & ~deb_q[NUM_SW-1:0];
`endif
    assign del_rise = deb[NUM_SW] & ~deb_q[NUM_SW];

    // Debouncers are still settling during ARM, so their edges are dropped.
    assign edges_en = (state != ARM);
    assign take_add = (state == IDLE) && (pending != '0);
    assign take_del = (state == IDLE) && (pending == '0) && del_pend;
    assign sel      = lowest_index(pending);
    assign clr      = take_add ? (NUM_SW'(1) << sel) : '0;

    // Pulse selection is latched on the IDLE->PULSE edge so hex updates in
    // exactly the cycle add goes high; new edges are OR-ed in after clearing.
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            pending  <= '0;
            del_pend <= 1'b0;
            hex_q    <= '0;
            is_add   <= 1'b0;
        end else begin
            pending  <= (pending & ~clr) | (edges_en ? sw_evt : '0);
            del_pend <= (del_pend & ~take_del) | (edges_en & del_rise);
            if (take_add) begin
                hex_q  <= sel;
                is_add <= 1'b1;
            end else if (take_del) begin
                is_add <= 1'b0;
            end
        end
    end

    // cnt reads 0 in the PULSE cycle and 1.. through HOLDOFF, so leaving
    // HOLDOFF at PULSE_GAP-2 puts the next PULSE exactly PULSE_GAP later.
    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state <= ARM;
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ARM:     cnt <= cnt + CNT_W'(1);
                IDLE:    cnt <= '0;
                PULSE:   cnt <= CNT_W'(1);
                HOLDOFF: cnt <= cnt + CNT_W'(1);
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARM:     if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) state_next = IDLE;
            IDLE:    if (take_add || take_del) state_next = PULSE;
            PULSE:   state_next = HOLDOFF;
            HOLDOFF: if (cnt == CNT_W'(PULSE_GAP - 2)) state_next = IDLE;
            default: state_next = ARM;
        endcase
    end

    always_comb begin
        bus.hex  = hex_q;
        bus.add  = (state == PULSE) && is_add;
        bus.del  = (state == PULSE) && !is_add;
        bus.busy = (state != IDLE) || (pending != '0) || del_pend;
    end

endmodule

// File: tb/tb_hex_key_encoder.sv
// Self-checking bench for hex_key_encoder (DEBOUNCE_CYCLES=4, PULSE_GAP=8).
// Expected pulses are queued when stimulus is driven and popped by a monitor
// on every add/del; pulse timestamps are used to check spacing.
module tb_hex_key_encoder;

    localparam int unsigned DEB = 4;
    localparam int unsigned GAP = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hex_key_encoder_if bus ();

    hex_key_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_GAP       (GAP),
        .CNT_W           (8)
    ) dut (
        .sys_clk  (clk),
        .sys_rstn (rstn),
        .bus      (bus.slave)
    );

    typedef struct packed {
        logic       is_del;
        logic [3:0] h;
    } ev_t;

    typedef struct {
        logic [15:0] mask;
        logic        del;
    } vec_t;

    ev_t         exp_q[$];
    int unsigned ptimes[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  prev_hex = '0;
    logic        prev_add = 1'b0;
    vec_t        tbl[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop, overlap, single-cycle add, hex hold.
    always @(negedge clk) begin
        ev_t e;
        if (!rstn) begin
            prev_hex = bus.hex;
            prev_add = 1'b0;
        end else begin
            if (bus.add && bus.del) begin
                n_cmp++; n_bad++;
                $display("FAIL overlap: add=%b del=%b, want not both", bus.add, bus.del);
            end
            if (bus.add && prev_add) begin
                n_cmp++; n_bad++;
                $display("FAIL add_width: add high 2 cycles, want 1");
            end
            if (bus.hex !== prev_hex && !bus.add) begin
                n_cmp++; n_bad++;
                $display("FAIL hex_hold: hex %0h->%0h without add", prev_hex, bus.hex);
            end
            if (bus.add || bus.del) begin
                ptimes.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse: add=%b del=%b hex=%0h, want none",
                             bus.add, bus.del, bus.hex);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_del !== bus.del || (!e.is_del && e.h !== bus.hex)) begin
                        n_bad++;
                        $display("FAIL pulse: got del=%b hex=%0h, want del=%b hex=%0h",
                                 bus.del, bus.hex, e.is_del, e.h);
                    end
                end
            end
            prev_hex = bus.hex;
            prev_add = bus.add;
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_add(input int unsigned i);
        ev_t e;
        e.is_del = 1'b0;
        e.h      = 4'(i);
        exp_q.push_back(e);
    endtask

    task automatic push_del();
        ev_t e;
        e.is_del = 1'b1;
        e.h      = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_release(input logic [15:0] mask);
`ifdef HEX_KEY_BOTH_EDGES_EN
        for (int unsigned i = 0; i < 16; i++) if (mask[i]) push_add(i);
`else
        if (mask != mask) push_add(0);
`endif
    endtask

    task automatic drain(input string name);
        int unsigned k;
        tick(12);
        k = 0;
        while ((exp_q.size() != 0 || bus.busy) && k < 400) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (k >= 400) begin
            n_bad++;
            $display("FAIL %s_drain: %0d events outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic check_spacing(input string name);
        for (int k = 0; k + 1 < ptimes.size(); k++)
            check(name, ptimes[k+1] - ptimes[k], GAP);
    endtask

    initial begin
        int unsigned n_exp;
        int unsigned k;

        tbl[0] = '{16'h0001, 1'b0};
        tbl[1] = '{16'h8000, 1'b0};
        tbl[2] = '{16'h0204, 1'b0};
        tbl[3] = '{16'h0008, 1'b1};
        tbl[4] = '{16'h0000, 1'b1};
        tbl[5] = '{16'h0F00, 1'b0};
        tbl[6] = '{16'h0080, 1'b0};

        // Reset with sw[4] already on: no add may come out of ARM.
        bus.sw      = 16'h0010;
        bus.btn_del = 1'b0;
        rstn        = 1'b0;
        tick(5);
        check("rst_hex",  32'(bus.hex),  32'd0);
        check("rst_add",  32'(bus.add),  32'd0);
        check("rst_del",  32'(bus.del),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);
        rstn = 1'b1;
        tick(3);
        check("arm_busy", 32'(bus.busy), 32'd1);
        tick(1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        tick(20);
        check("arm_no_add", ptimes.size(), 32'd0);
        check("arm_hex", 32'(bus.hex), 32'd0);
        bus.sw = 16'h0000;
        push_release(16'h0010);
        drain("arm_release");

        // Table-driven single-shot patterns.
        for (int unsigned r = 0; r < 7; r++) begin
            ptimes.delete();
            n_exp = 0;
            for (int unsigned i = 0; i < 16; i++)
                if (tbl[r].mask[i]) begin push_add(i); n_exp++; end
            if (tbl[r].del) begin push_del(); n_exp++; end
            bus.sw      = tbl[r].mask;
            bus.btn_del = tbl[r].del;
            tick(10);
            bus.btn_del = 1'b0;
            drain("vec");
            check("vec_count", ptimes.size(), n_exp);
            check_spacing("vec_gap");

            ptimes.delete();
            n_exp = 0;
`ifdef HEX_KEY_BOTH_EDGES_EN
            for (int unsigned i = 0; i < 16; i++) if (tbl[r].mask[i]) n_exp++;
`endif
            push_release(tbl[r].mask);
            bus.sw = 16'h0000;
            drain("vec_off");
            check("vec_off_count", ptimes.size(), n_exp);
            check_spacing("vec_off_gap");
        end

        // sw[5] bounces shorter than DEB cycles, then settles high.
        ptimes.delete();
        push_add(5);
        bus.sw[5] = 1'b1; tick(2);
        bus.sw[5] = 1'b0; tick(2);
        bus.sw[5] = 1'b1; tick(1);
        bus.sw[5] = 1'b0; tick(2);
        bus.sw[5] = 1'b1; tick(3);
        bus.sw[5] = 1'b0; tick(1);
        bus.sw[5] = 1'b1;
        drain("bounce");
        check("bounce_count", ptimes.size(), 32'd1);
        check("bounce_hex", 32'(bus.hex), 32'd5);
        push_release(16'h0020);
        bus.sw = 16'h0000;
        drain("bounce_off");

        // btn_del debounces while the sw[1] add is in HOLDOFF.
        ptimes.delete();
        push_add(1);
        push_del();
        bus.sw = 16'h0002;
        tick(3);
        bus.btn_del = 1'b1;
        tick(10);
        bus.btn_del = 1'b0;
        drain("del_holdoff");
        check("del_holdoff_count", ptimes.size(), 32'd2);
        check_spacing("del_holdoff_gap");
        push_release(16'h0002);
        bus.sw = 16'h0000;
        drain("del_holdoff_off");

        // Reset during HOLDOFF with two adds still pending.
        ptimes.delete();
        push_add(1);
        bus.sw = 16'h000E;
        k = 0;
        while (ptimes.size() == 0 && k < 100) begin tick(1); k++; end
        check("rst_mid_first", ptimes.size(), 32'd1);
        tick(2);
        rstn = 1'b0;
        tick(3);
        check("rst_mid_hex",  32'(bus.hex),  32'd0);
        check("rst_mid_add",  32'(bus.add),  32'd0);
        check("rst_mid_del",  32'(bus.del),  32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd1);
        exp_q.delete();
        rstn = 1'b1;
        tick(40);
        check("rst_mid_no_replay", ptimes.size(), 32'd1);
        push_release(16'h000E);
        bus.sw = 16'h0000;
        drain("rst_mid_off");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
